motor_profile_feeder: RTL and testbench

//  Producer end of the pul_value/read interface of ddr_motor_ctrl.
//  - Generates a trapezoidal pulse-period profile: accelerate, cruise, decelerate.
//  - Presents the period for the next pulse on pul_value and advances one entry per read strobe.
//  - Derives the step/accel_end/decel_begin configuration consumed by the motor controller.
//  - Sits between the host config registers and ddr_motor_ctrl.

---
 rtl/motor_ctrl_pkg.sv | 23 ++
 rtl/motor_sat_addsub.sv | 47 ++++
 rtl/motor_profile_feeder.sv | 214 +++++++++++++++++++++
 tb/tb_motor_profile_feeder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor profile feeder.
// Holds the profile state encoding, the add/subtract selector for the
// saturating arithmetic unit and the default datapath widths.
package motor_ctrl_pkg;

  // Default widths: period values, step counters, accel/decel indices
  localparam int PW = 32;
  localparam int SW = 32;
  localparam int AW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_e;

  typedef enum logic {
    OP_SUB = 1'b0,
    OP_ADD = 1'b1
  } op_e;

endpackage

// File: rtl/motor_sat_addsub.sv
// Saturating period step unit (purely combinational).
// Ports:
//   a      in  PW  current period
//   delta  in  PW  step size
//   floor  in  PW  lower bound applied after subtraction
//   ceil   in  PW  upper bound applied to every result
//   op     in  1   OP_SUB or OP_ADD
//   result out PW  a -/+ delta clamped into [floor, ceil]
// The ceiling is applied last, so a floor above the ceiling pins the result
// at the ceiling.
module motor_sat_addsub
  import motor_ctrl_pkg::*;
#(
  parameter int PW = motor_ctrl_pkg::PW
) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] delta,
  input  logic [PW-1:0] floor,
  input  logic [PW-1:0] ceil,
  input  op_e           op,
  output logic [PW-1:0] result
);

  logic [PW:0]   diff_s;
  logic [PW:0]   sum_s;
  logic [PW-1:0] lo_s;

  // One extra bit catches borrow on subtract and carry on add
  always_comb begin
    diff_s = {1'b0, a} - {1'b0, delta};
    sum_s  = {1'b0, a} + {1'b0, delta};
    lo_s   = {PW{1'b0}};
    result = {PW{1'b0}};
    if (op == OP_SUB) begin
      if (diff_s[PW] || (diff_s[PW-1:0] < floor)) begin
        lo_s = floor;
      end else begin
        lo_s = diff_s[PW-1:0];
      end
      result = (lo_s > ceil) ? ceil : lo_s;
    end else begin
      lo_s   = {PW{1'b0}};
      result = (sum_s > {1'b0, ceil}) ? ceil : sum_s[PW-1:0];
    end
  end

endmodule

// File: rtl/motor_profile_feeder.sv
// Trapezoidal pulse-period profile generator feeding ddr_motor_ctrl.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, abort      1-cycle control pulses (abort has priority)
//   start_period      slowest period (first/last pulse and ceiling)
//   min_period        fastest period (floor while accelerating)
//   delta             per-pulse period change
//   accel_steps       requested accel length A
//   total_steps       pulses in the move N
//   read              consumer strobe: pul_value for index k consumed
//   pul_value         period for the current index k
//   step              latched N
//   accel_end         Ae-1 (0 when Ae==0)
//   decel_begin       N-Ae truncated to AW bits
//   busy              high while a move is in progress
//   done              1-cycle pulse after index N-1 is consumed
//   rd_err            sticky, read seen while idle; cleared by start
module motor_profile_feeder
  import motor_ctrl_pkg::*;
#(
  parameter int PW = motor_ctrl_pkg::PW,
  parameter int SW = motor_ctrl_pkg::SW,
  parameter int AW = motor_ctrl_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] start_period,
  input  logic [PW-1:0] min_period,
  input  logic [PW-1:0] delta,
  input  logic [AW-1:0] accel_steps,
  input  logic [SW-1:0] total_steps,
  input  logic          read,
  output logic [PW-1:0] pul_value,
  output logic [SW-1:0] step,
  output logic [AW-1:0] accel_end,
  output logic [AW-1:0] decel_begin,
  output logic          busy,
  output logic          done,
  output logic          rd_err
);

  localparam logic [SW-1:0] ONE_SW = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_AW = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [SW-1:0] k_q, k_d;
  logic [PW-1:0] pul_q, pul_d;
  logic [PW-1:0] sp_q, sp_d;
  logic [PW-1:0] mp_q, mp_d;
  logic [PW-1:0] dl_q, dl_d;
  logic [SW-1:0] n_q, n_d;
  logic [SW-1:0] ae_q, ae_d;
  logic [SW-1:0] dd_q, dd_d;
  logic [AW-1:0] aend_q, aend_d;
  logic [AW-1:0] dbeg_q, dbeg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_err_q, rd_err_d;

  logic [SW:0]   two_a_s;
  logic [SW-1:0] ae_s;
  logic [SW-1:0] d_s;
  logic [SW-1:0] j_s;
  op_e           op_s;
  logic [PW-1:0] sat_s;

  // Effective accel length: a move too short for 2*A pulses splits evenly
  always_comb begin
    two_a_s = {{(SW-AW){1'b0}}, accel_steps, 1'b0};
    if (two_a_s > {1'b0, total_steps}) begin
      ae_s = {1'b0, total_steps[SW-1:1]};
    end else begin
      ae_s = {{(SW-AW){1'b0}}, accel_steps};
    end
    d_s  = total_steps - ae_s;
    j_s  = k_q + ONE_SW;
    op_s = (j_s < ae_q) ? OP_SUB : OP_ADD;
  end

  motor_sat_addsub #(.PW(PW)) u_sat (
    .a      (pul_q),
    .delta  (dl_q),
    .floor  (mp_q),
    .ceil   (sp_q),
    .op     (op_s),
    .result (sat_s)
  );

  // Next-state: profile FSM, index counter, config latches and output values
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    pul_d    = pul_q;
    sp_d     = sp_q;
    mp_d     = mp_q;
    dl_d     = dl_q;
    n_d      = n_q;
    ae_d     = ae_q;
    dd_d     = dd_q;
    aend_d   = aend_q;
    dbeg_d   = dbeg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_err_d = rd_err_q;
    if (abort) begin
      // Abort drops any simultaneous start or read; outputs hold
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sp_d     = start_period;
            mp_d     = min_period;
            dl_d     = delta;
            n_d      = total_steps;
            ae_d     = ae_s;
            dd_d     = d_s;
            aend_d   = (ae_s == {SW{1'b0}}) ? {AW{1'b0}} : (ae_s[AW-1:0] - ONE_AW);
            dbeg_d   = d_s[AW-1:0];
            k_d      = {SW{1'b0}};
            rd_err_d = 1'b0;
            if (total_steps == {SW{1'b0}}) begin
              done_d = 1'b1;
            end else begin
              pul_d   = start_period;
              busy_d  = 1'b1;
              state_d = (ae_s != {SW{1'b0}}) ? ST_ACCEL : ST_CRUISE;
            end
          end else if (read) begin
            rd_err_d = 1'b1;
          end else begin
            rd_err_d = rd_err_q;
          end
        end
        ST_ACCEL, ST_CRUISE, ST_DECEL: begin
          if (read) begin
            k_d = j_s;
            // Accel and decel indices step the period; the plateau holds it
            if ((j_s < ae_q) || (j_s > dd_q)) begin
              pul_d = sat_s;
            end else begin
              pul_d = pul_q;
            end
            // State follows the phase of j directly, so phases can be skipped
            if (k_q == (n_q - ONE_SW)) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (j_s < ae_q) begin
              state_d = ST_ACCEL;
            end else if (j_s <= dd_q) begin
              state_d = ST_CRUISE;
            end else begin
              state_d = ST_DECEL;
            end
          end else begin
            k_d = k_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      k_q      <= {SW{1'b0}};
      pul_q    <= {PW{1'b0}};
      sp_q     <= {PW{1'b0}};
      mp_q     <= {PW{1'b0}};
      dl_q     <= {PW{1'b0}};
      n_q      <= {SW{1'b0}};
      ae_q     <= {SW{1'b0}};
      dd_q     <= {SW{1'b0}};
      aend_q   <= {AW{1'b0}};
      dbeg_q   <= {AW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      pul_q    <= pul_d;
      sp_q     <= sp_d;
      mp_q     <= mp_d;
      dl_q     <= dl_d;
      n_q      <= n_d;
      ae_q     <= ae_d;
      dd_q     <= dd_d;
      aend_q   <= aend_d;
      dbeg_q   <= dbeg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign pul_value   = pul_q;
  assign step        = n_q;
  assign accel_end   = aend_q;
  assign decel_begin = dbeg_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_motor_profile_feeder.sv
// Randomized bench for motor_profile_feeder against an arithmetic profile model.
module tb_motor_profile_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] start_period;
  logic [31:0] min_period;
  logic [31:0] delta;
  logic [15:0] accel_steps;
  logic [31:0] total_steps;
  logic        read;
  logic [31:0] pul_value;
  logic [31:0] step;
  logic [15:0] accel_end;
  logic [15:0] decel_begin;
  logic        busy;
  logic        done;
  logic        rd_err;

  int     n_checks;
  int     n_errors;
  longint exp_v [0:599];
  longint ae_m;
  longint d_m;

  motor_profile_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .start_period (start_period),
    .min_period   (min_period),
    .delta        (delta),
    .accel_steps  (accel_steps),
    .total_steps  (total_steps),
    .read         (read),
    .pul_value    (pul_value),
    .step         (step),
    .accel_end    (accel_end),
    .decel_begin  (decel_begin),
    .busy         (busy),
    .done         (done),
    .rd_err       (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Profile model: index k period from the accel/plateau/decel rules
  function automatic void build(input int n, input int a, input longint sp,
                                input longint mp, input longint dl);
    longint v;
    ae_m = (2 * a > n) ? (n / 2) : a;
    d_m  = n - ae_m;
    v    = sp;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        if (k < ae_m) begin
          v = v - dl;
          if (v < mp) v = mp;
          if (v > sp) v = sp;
        end else if (k > d_m) begin
          v = v + dl;
          if (v > sp) v = sp;
        end
      end
      exp_v[k] = v;
    end
  endfunction

  task automatic do_move(input int n, input int a, input longint sp, input longint mp,
                         input longint dl, input int gap_lo, input int gap_hi,
                         input int abort_k);
    int gap;
    build(n, a, sp, mp, dl);
    @(negedge clk);
    start        = 1'b1;
    total_steps  = 32'(n);
    accel_steps  = 16'(a);
    start_period = 32'(sp);
    min_period   = 32'(mp);
    delta        = 32'(dl);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk("n0_done", done, 1);
      chk("n0_busy", busy, 0);
      chk("n0_step", step, 0);
      @(negedge clk);
      chk("n0_done_once", done, 0);
      chk("n0_busy2", busy, 0);
      return;
    end
    chk("busy_start", busy, 1);
    chk("rd_err_clr", rd_err, 0);
    chk("step", step, n);
    chk("accel_end", accel_end, (ae_m == 0) ? 0 : ae_m - 1);
    chk("decel_begin", decel_begin, (n - ae_m) & 16'hFFFF);
    for (int k = 0; k < n; k++) begin
      chk("pul", pul_value, exp_v[k]);
      chk("done_mid", done, 0);
      if (k == abort_k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hold", pul_value, exp_v[k]);
        chk("abort_nodone", done, 0);
        @(negedge clk);
        chk("abort_nodone2", done, 0);
        chk("abort_step", step, n);
        return;
      end
      read  = 1'b1;
      start = (k == 1);
      @(negedge clk);
      read  = 1'b0;
      start = 1'b0;
      if (k != n - 1) begin
        gap = $urandom_range(gap_hi, gap_lo);
        repeat (gap) @(negedge clk);
      end
    end
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("pul_last", pul_value, exp_v[n-1]);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("pul_hold", pul_value, exp_v[n-1]);
  endtask

  initial begin
    int n, a;
    longint sp, mp, dl;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    read         = 1'b0;
    start_period = 32'd0;
    min_period   = 32'd0;
    delta        = 32'd0;
    accel_steps  = 16'd0;
    total_steps  = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_pul", pul_value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step, 0);
    rst = 1'b1;

    // Directed profiles
    do_move(10, 8, 100, 0, 10, 0, 3, -1);
    do_move(8, 4, 100, 50, 30, 0, 2, -1);
    do_move(4, 0, 700, 10, 25, 0, 2, -1);
    do_move(6, 3, 300, 500, 40, 0, 1, -1);
    do_move(1, 5, 123, 1, 7, 0, 1, -1);
    do_move(0, 3, 400, 10, 5, 0, 0, -1);
    do_move(20, 6, 900, 100, 50, 0, 0, -1);

    // Abort at k=3 then read while idle
    do_move(12, 4, 500, 100, 20, 0, 1, 3);
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chk("rd_err_set", rd_err, 1);
    chk("rd_err_pul_hold", pul_value, exp_v[3]);
    @(negedge clk);
    chk("rd_err_sticky", rd_err, 1);

    // Start and abort together: stays idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    total_steps = 32'd5;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_done", done, 0);
    @(negedge clk);
    chk("sa_busy2", busy, 0);
    chk("sa_rd_err", rd_err, 1);

    // Long move, read every 50 cycles
    do_move(500, 250, 1000, 100, 2, 49, 49, -1);

    // Randomized moves
    for (int i = 0; i < 10; i++) begin
      n  = $urandom_range(40, 1);
      a  = $urandom_range(30, 0);
      sp = $urandom_range(2000, 50);
      mp = $urandom_range(32'(sp + 200), 0);
      dl = $urandom_range(300, 0);
      do_move(n, a, sp, mp, dl, 0, 3, -1);
    end

    // Asynchronous reset mid-move
    @(negedge clk);
    start        = 1'b1;
    total_steps  = 32'd20;
    accel_steps  = 16'd5;
    start_period = 32'd800;
    min_period   = 32'd10;
    delta        = 32'd30;
    @(negedge clk);
    start = 1'b0;
    read  = 1'b1;
    repeat (3) @(negedge clk);
    read = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pul", pul_value, 0);
    chk("arst_busy", busy, 0);
    chk("arst_step", step, 0);
    chk("arst_aend", accel_end, 0);
    chk("arst_dbeg", decel_begin, 0);
    chk("arst_done", done, 0);
    chk("arst_rd_err", rd_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
